// File: rtl/rgb2gray_pipe_if.sv
// Pixel stream bundle for rgb2gray_pipe: RGB beats in, gray beats out, valid/ready on both sides.
// The master modport is the surrounding environment; the slave modport is the converter.
interface rgb2gray_pipe_if #(
  parameter int unsigned WIDTH_P = 8,
  parameter int unsigned LANES_P = 1
) ();

  logic                       valid_i;
  logic                       ready_o;
  logic [LANES_P*WIDTH_P-1:0] red_i;
  logic [LANES_P*WIDTH_P-1:0] green_i;
  logic [LANES_P*WIDTH_P-1:0] blue_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [LANES_P*WIDTH_P-1:0] gray_o;

  modport master (
    output valid_i,
    output red_i,
    output green_i,
    output blue_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  gray_o
  );

  modport slave (
    input  valid_i,
    input  red_i,
    input  green_i,
    input  blue_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output gray_o
  );

endinterface

// File: rtl/rgb2gray_pipe.sv
// Multi-lane RGB to luma converter: programmable fixed-point coefficients, rounding, saturation,
// two-stage valid/ready pipeline. Define RGB2GRAY_PIPE_SAT_CNT_EN to add the sat_cnt_o counter.
module rgb2gray_pipe #(
  parameter int unsigned WIDTH_P  = 8,
  parameter int unsigned LANES_P  = 1,
  parameter int unsigned COEF_W_P = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_sel_i,
  input  logic [COEF_W_P-1:0] cfg_coef_i,
  rgb2gray_pipe_if.slave      pix_if
`ifdef RGB2GRAY_PIPE_SAT_CNT_EN
  ,
  output logic [15:0]         sat_cnt_o
`endif
);

  localparam int unsigned ProdW = WIDTH_P + COEF_W_P;
  localparam int unsigned AccW  = ProdW + 2;
  localparam int unsigned DataW = LANES_P * WIDTH_P;

  localparam logic [COEF_W_P-1:0] CrRst = COEF_W_P'(77) << (COEF_W_P - 8);
  localparam logic [COEF_W_P-1:0] CgRst = COEF_W_P'(150) << (COEF_W_P - 8);
  localparam logic [COEF_W_P-1:0] CbRst = COEF_W_P'(29) << (COEF_W_P - 8);

  localparam logic [AccW-1:0] RoundHalf = AccW'(1) << (COEF_W_P - 1);
  localparam logic [AccW-1:0] MaxGray   = (AccW'(1) << WIDTH_P) - AccW'(1);

  // Coefficient registers
  logic [COEF_W_P-1:0] cr_q, cr_d;
  logic [COEF_W_P-1:0] cg_q, cg_d;
  logic [COEF_W_P-1:0] cb_q, cb_d;

  // Pipeline control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic adv2;
  logic ready;
  logic capture;

  // Stage 1 products and stage 2 result
  logic [LANES_P-1:0][ProdW-1:0] prod_r_q, prod_r_d;
  logic [LANES_P-1:0][ProdW-1:0] prod_g_q, prod_g_d;
  logic [LANES_P-1:0][ProdW-1:0] prod_b_q, prod_b_d;
  logic [DataW-1:0]              gray_q, gray_d;
  logic [LANES_P-1:0]            lane_sat;
  logic [AccW-1:0]               acc;
  logic [AccW-1:0]               res;

  always_comb begin
    cr_d = cr_q;
    cg_d = cg_q;
    cb_d = cb_q;
    if (cfg_we_i) begin
      case (cfg_sel_i)
        2'd0:    cr_d = cfg_coef_i;
        2'd1:    cg_d = cfg_coef_i;
        2'd2:    cb_d = cfg_coef_i;
        default: ;
      endcase
    end
  end

  assign adv2    = s1_valid_q & (~s2_valid_q | pix_if.ready_i);
  assign ready   = ~s1_valid_q | adv2;
  assign capture = pix_if.valid_i & ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (capture) begin
      s1_valid_d = 1'b1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
    if (adv2) begin
      s2_valid_d = 1'b1;
    end else if (pix_if.ready_i) begin
      s2_valid_d = 1'b0;
    end
  end

  // Products use the coefficients current at capture, so later writes never touch in-flight beats.
  always_comb begin
    prod_r_d = '0;
    prod_g_d = '0;
    prod_b_d = '0;
    for (int unsigned l = 0; l < LANES_P; l++) begin
      prod_r_d[l] = ProdW'(pix_if.red_i[l*WIDTH_P +: WIDTH_P]) * ProdW'(cr_q);
      prod_g_d[l] = ProdW'(pix_if.green_i[l*WIDTH_P +: WIDTH_P]) * ProdW'(cg_q);
      prod_b_d[l] = ProdW'(pix_if.blue_i[l*WIDTH_P +: WIDTH_P]) * ProdW'(cb_q);
    end
  end

  always_comb begin
    gray_d   = '0;
    lane_sat = '0;
    acc      = '0;
    res      = '0;
    for (int unsigned l = 0; l < LANES_P; l++) begin
      acc = AccW'(prod_r_q[l]) + AccW'(prod_g_q[l]) + AccW'(prod_b_q[l]) + RoundHalf;
      res = acc >> COEF_W_P;
      lane_sat[l] = (res > MaxGray);
      gray_d[l*WIDTH_P +: WIDTH_P] = lane_sat[l] ? {WIDTH_P{1'b1}} : res[WIDTH_P-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr_q       <= CrRst;
      cg_q       <= CgRst;
      cb_q       <= CbRst;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      prod_r_q   <= '0;
      prod_g_q   <= '0;
      prod_b_q   <= '0;
      gray_q     <= '0;
    end else begin
      cr_q       <= cr_d;
      cg_q       <= cg_d;
      cb_q       <= cb_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (capture) begin
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
      end
      // Stage 2 only moves on adv2, which keeps gray_o stable under backpressure.
      if (adv2) begin
        gray_q <= gray_d;
      end
    end
  end

  assign pix_if.ready_o = ready;
  assign pix_if.valid_o = s2_valid_q;
  assign pix_if.gray_o  = gray_q;

`ifdef RGB2GRAY_PIPE_SAT_CNT_EN
  logic [LANES_P-1:0] sat_q;
  logic [15:0]        sat_cnt_q, sat_cnt_d;
  logic [16:0]        sat_sum;

  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q};
    sat_cnt_d = sat_cnt_q;
    for (int unsigned l = 0; l < LANES_P; l++) begin
      sat_sum = sat_sum + 17'(sat_q[l]);
    end
    if (s2_valid_q && pix_if.ready_i) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_q     <= '0;
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      if (adv2) begin
        sat_q <= lane_sat;
      end
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Self-checking bench for rgb2gray_pipe (two lanes): directed vector table, handshake corner
// sequences and a randomized run against a queue-based luma reference model.
module tb_rgb2gray_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned L  = 2;
  localparam int unsigned C  = 8;
  localparam int unsigned DW = L * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [1:0]   cfg_sel;
  logic [C-1:0] cfg_coef;
`ifdef RGB2GRAY_PIPE_SAT_CNT_EN
  logic [15:0]  sat_cnt;
`endif

  rgb2gray_pipe_if #(.WIDTH_P(W), .LANES_P(L)) pif ();

  rgb2gray_pipe #(
    .WIDTH_P (W),
    .LANES_P (L),
    .COEF_W_P(C)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cfg_we_i  (cfg_we),
    .cfg_sel_i (cfg_sel),
    .cfg_coef_i(cfg_coef),
    .pix_if    (pif.slave)
`ifdef RGB2GRAY_PIPE_SAT_CNT_EN
    ,
    .sat_cnt_o (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] g;
    int            nsat;
  } exp_t;

  typedef struct {
    logic [7:0] r0, g0, b0, r1, g1, b1, e0, e1;
  } vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_cr  = 77;
  int   m_cg  = 150;
  int   m_cb  = 29;
  int   m_sat = 0;
  int   m_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Luma from first principles: weighted sum of channels, round half up, fraction dropped.
  function automatic int lum(input int r, input int g, input int b);
    return (r * m_cr + g * m_cg + b * m_cb + (1 << (C - 1))) / (1 << C);
  endfunction

  // Called once per cycle at the falling edge: scores the handshakes of the coming rising edge.
  task automatic monitor();
    exp_t e;
    if (rst === 1'b1) begin
      q.delete();
      m_cr  = 77;
      m_cg  = 150;
      m_cb  = 29;
      m_sat = 0;
    end else begin
`ifdef RGB2GRAY_PIPE_SAT_CNT_EN
      check("sat_cnt", 32'(sat_cnt), 32'(m_sat));
`endif
      if (pif.valid_o === 1'b1 && pif.ready_i === 1'b1) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got gray %0h, required no beat", pif.gray_o);
        end else begin
          e = q.pop_front();
          check("stream_gray", 32'(pif.gray_o), 32'(e.g));
          m_sat = m_sat + e.nsat;
          if (m_sat > 65535) m_sat = 65535;
        end
      end
      if (pif.valid_i === 1'b1 && pif.ready_o === 1'b1) begin
        e.g    = '0;
        e.nsat = 0;
        for (int l = 0; l < L; l++) begin
          int v;
          v = lum(int'(pif.red_i[l*W +: W]), int'(pif.green_i[l*W +: W]),
                  int'(pif.blue_i[l*W +: W]));
          if (v > 255) begin
            v = 255;
            e.nsat++;
          end
          e.g[l*W +: W] = 8'(v);
        end
        q.push_back(e);
        m_acc++;
      end
      if (cfg_we === 1'b1) begin
        case (cfg_sel)
          2'd0:    m_cr = int'(cfg_coef);
          2'd1:    m_cg = int'(cfg_coef);
          2'd2:    m_cb = int'(cfg_coef);
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [7:0] r0, g0, b0, r1, g1, b1);
    pif.red_i   = {r1, r0};
    pif.green_i = {g1, g0};
    pif.blue_i  = {b1, b0};
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 8 && pif.valid_o !== 1'b1; k++) tick();
    check(name, 32'(pif.valid_o), 32'd1);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] coef);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_coef = coef;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   nv;
    int   base;
    vt[0] = '{8'd200, 8'd200, 8'd200, 8'd255, 8'd0,   8'd0,   8'd200, 8'd77};
    vt[1] = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd149, 8'd0};
    vt[2] = '{8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd77,  8'd29};
    vt[3] = '{8'd255, 8'd255, 8'd255, 8'd10,  8'd10,  8'd10,  8'd255, 8'd10};
    vt[4] = '{8'd0,   8'd0,   8'd255, 8'd128, 8'd64,  8'd32,  8'd29,  8'd80};

    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_sel     = 2'd0;
    cfg_coef    = '0;
    pif.valid_i = 1'b0;
    pif.ready_i = 1'b1;
    set_pix(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid_o", 32'(pif.valid_o), 32'd0);
    check("reset_gray_o", 32'(pif.gray_o), 32'd0);
    check("reset_ready_o", 32'(pif.ready_o), 32'd1);

    // Directed vectors, default coefficients
    for (int i = 0; i < 5; i++) begin
      set_pix(vt[i].r0, vt[i].g0, vt[i].b0, vt[i].r1, vt[i].g1, vt[i].b1);
      pif.valid_i = 1'b1;
      tick();
      pif.valid_i = 1'b0;
      wait_valid("table_wait");
      check("table_lane0", 32'(pif.gray_o[7:0]), 32'(vt[i].e0));
      check("table_lane1", 32'(pif.gray_o[15:8]), 32'(vt[i].e1));
      tick();
    end

    // Single-beat latency
    set_pix(255, 0, 0, 0, 0, 255);
    pif.valid_i = 1'b1;
    tick();
    pif.valid_i = 1'b0;
    check("lat_after_e0", 32'(pif.valid_o), 32'd0);
    tick();
    check("lat_after_e1", 32'(pif.valid_o), 32'd1);
    check("lat_gray", 32'(pif.gray_o), {16'd0, 8'd29, 8'd77});
    tick();
    check("lat_after_e2", 32'(pif.valid_o), 32'd0);

    // Ten back-to-back beats
    nv = 0;
    base = 0;
    for (int k = 0; k < 10; k++) begin
      set_pix(8'(k * 20), 8'(k * 7), 8'(255 - k), 8'(k), 8'(k * 25), 8'(k * 3));
      pif.valid_i = 1'b1;
      if (pif.ready_o !== 1'b1) base++;
      tick();
      if (pif.valid_o === 1'b1) nv++;
    end
    pif.valid_i = 1'b0;
    tick();
    if (pif.valid_o === 1'b1) nv++;
    tick();
    check("b2b_ready_low_cycles", 32'(base), 32'd0);
    check("b2b_output_count", 32'(nv), 32'd10);
    check("b2b_tail_valid", 32'(pif.valid_o), 32'd0);

    // Backpressure: two beats buffered, then release
    pif.ready_i = 1'b0;
    base = m_acc;
    for (int k = 0; k < 6; k++) begin
      nv = (m_acc - base + 1) * 10;
      set_pix(8'(nv), 8'(nv), 8'(nv), 8'(nv + 1), 8'(nv + 1), 8'(nv + 1));
      pif.valid_i = 1'b1;
      tick();
    end
    check("bp_accepts", 32'(m_acc - base), 32'd2);
    check("bp_ready_o", 32'(pif.ready_o), 32'd0);
    check("bp_hold_gray", 32'(pif.gray_o[7:0]), 32'd10);
    pif.ready_i = 1'b1;
    for (int k = 0; k < 20 && (m_acc - base) < 4; k++) begin
      nv = (m_acc - base + 1) * 10;
      set_pix(8'(nv), 8'(nv), 8'(nv), 8'(nv + 1), 8'(nv + 1), 8'(nv + 1));
      pif.valid_i = 1'b1;
      tick();
    end
    pif.valid_i = 1'b0;
    check("bp_all_accepted", 32'(m_acc - base), 32'd4);
    for (int k = 0; k < 10 && (q.size() != 0 || pif.valid_o === 1'b1); k++) tick();
    check("bp_drained", 32'(q.size()), 32'd0);

    // Saturation with all-ones coefficients
    cfg_write(2'd0, 8'd255);
    cfg_write(2'd1, 8'd255);
    cfg_write(2'd2, 8'd255);
    set_pix(255, 255, 255, 0, 0, 0);
    pif.valid_i = 1'b1;
    tick();
    pif.valid_i = 1'b0;
    wait_valid("sat_wait");
    check("sat_gray", 32'(pif.gray_o), {16'd0, 8'd0, 8'd255});
    tick();
`ifdef RGB2GRAY_PIPE_SAT_CNT_EN
    check("sat_cnt_one", 32'(sat_cnt), 32'd1);
`endif

    // Coefficient write on the same edge as a capture
    cfg_write(2'd0, 8'd77);
    cfg_write(2'd1, 8'd150);
    cfg_write(2'd2, 8'd29);
    cfg_we      = 1'b1;
    cfg_sel     = 2'd0;
    cfg_coef    = 8'd0;
    set_pix(255, 0, 0, 255, 0, 0);
    pif.valid_i = 1'b1;
    tick();
    cfg_we      = 1'b0;
    pif.valid_i = 1'b0;
    wait_valid("old_coef_wait");
    check("old_coef_gray", 32'(pif.gray_o), {16'd0, 8'd77, 8'd77});
    tick();
    cfg_write(2'd3, 8'd0);
    set_pix(255, 0, 0, 0, 255, 0);
    pif.valid_i = 1'b1;
    tick();
    pif.valid_i = 1'b0;
    wait_valid("new_coef_wait");
    check("new_coef_lane0", 32'(pif.gray_o[7:0]), 32'd0);
    check("sel3_ignored_lane1", 32'(pif.gray_o[15:8]), 32'd149);
    tick();

    // Reset with two beats in flight; cfg write in the reset cycle must be dropped
    pif.ready_i = 1'b0;
    set_pix(100, 100, 100, 50, 50, 50);
    pif.valid_i = 1'b1;
    tick();
    tick();
    pif.valid_i = 1'b0;
    check("rst_inflight_valid", 32'(pif.valid_o), 32'd1);
    rst      = 1'b1;
    cfg_we   = 1'b1;
    cfg_sel  = 2'd1;
    cfg_coef = 8'd0;
    tick();
    rst    = 1'b0;
    cfg_we = 1'b0;
    check("rst_valid_o", 32'(pif.valid_o), 32'd0);
    check("rst_ready_o", 32'(pif.ready_o), 32'd1);
    pif.ready_i = 1'b1;
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (pif.valid_o === 1'b1) nv++;
    end
    check("rst_no_stale", 32'(nv), 32'd0);
    set_pix(0, 255, 0, 255, 0, 0);
    pif.valid_i = 1'b1;
    tick();
    pif.valid_i = 1'b0;
    wait_valid("rst_after_wait");
    check("rst_after_gray", 32'(pif.gray_o), {16'd0, 8'd77, 8'd149});
    tick();

    // Randomized traffic with occasional coefficient writes
    for (int k = 0; k < 400; k++) begin
      pif.valid_i = ($urandom_range(0, 3) != 0);
      pif.ready_i = ($urandom_range(0, 3) != 0);
      cfg_we      = ($urandom_range(0, 15) == 0);
      cfg_sel     = 2'($urandom_range(0, 3));
      cfg_coef    = 8'($urandom_range(0, 255));
      set_pix(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom));
      tick();
    end
    pif.valid_i = 1'b0;
    pif.ready_i = 1'b1;
    cfg_we      = 1'b0;
    for (int k = 0; k < 10 && (q.size() != 0 || pif.valid_o === 1'b1); k++) tick();
    check("final_drained", 32'(q.size()), 32'd0);
    check("final_valid_o", 32'(pif.valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
